neo_result_reader: RTL and testbench

// - Read-side counterpart of the NEO calculator's memory writer: on start, fetches
//   `count` NEO results from the shared result memory, starting at base_addr with

---
 rtl/neo_result_reader.sv | 183 ++++++++++++++++++
 tb/tb_neo_result_reader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/neo_result_reader.sv
// Streams `count` words from the NEO result memory (circular from base_addr) as a
// valid/ready stream with a last marker. Optional peak tracker: define NEO_PEAK_EN.
module neo_result_reader #(
    parameter int N = 16,
    parameter int M = 16,
    localparam int AW = $clog2(M) + 1
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [AW-1:0]        base_addr,
    input  logic [AW-1:0]        count,
    output logic [AW-1:0]        raddr,
    input  logic signed [N-1:0]  rdata,
    output logic signed [N-1:0]  out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
`ifdef NEO_PEAK_EN
   ,output logic signed [N-1:0]  peak_val,
    output logic [AW-1:0]        peak_idx
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    localparam logic [AW-1:0] M_W = AW'(M);

    state_t              state_q, state_d;
    logic [AW-1:0]       raddr_q, raddr_d;
    logic [AW-1:0]       issued_q, issued_d;
    logic [AW-1:0]       total_q, total_d;
    logic [AW-1:0]       beats_q, beats_d;
    logic                pend1_q, pend1_d;
    logic                pend2_q;
    logic signed [N-1:0] fifo_q [4];
    logic [1:0]          wr_ptr_q, rd_ptr_q;
    logic [2:0]          occ_q, occ_d;

    logic [AW-1:0] count_clamped, base_wrapped, next_addr;
    logic [3:0]    inflight;
    logic          can_issue, push, pop;

    assign count_clamped = (count > M_W) ? M_W : count;
    // The address port is one bit wider than needed, so base_addr < 2*M and one subtract wraps it.
    assign base_wrapped  = (base_addr >= M_W) ? base_addr - M_W : base_addr;
    assign next_addr     = (raddr_q == M_W - 1'b1) ? '0 : raddr_q + 1'b1;

    // Reads already in the memory pipeline hold FIFO slots, so the FIFO can never overflow.
    assign inflight  = {1'b0, occ_q} + {3'b000, pend1_q} + {3'b000, pend2_q};
    assign can_issue = inflight < 4'd4;
    assign push      = pend2_q;
    assign pop       = out_valid && out_ready;

    assign out_valid = (occ_q != 3'd0);
    assign out_data  = out_valid ? fifo_q[rd_ptr_q] : '0;
    assign out_last  = out_valid && (beats_q == total_q - 1'b1);
    assign raddr     = raddr_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign occ_d     = occ_q + {2'b00, push} - {2'b00, pop};

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        raddr_d  = raddr_q;
        issued_d = issued_q;
        total_d  = total_q;
        beats_d  = beats_q;
        pend1_d  = 1'b0;
        if (pop) beats_d = beats_q + 1'b1;
        case (state_q)
            S_IDLE: if (start) begin
                total_d  = count_clamped;
                beats_d  = '0;
                issued_d = '0;
                if (count_clamped == '0) begin
                    state_d = S_DONE;
                end else begin
                    raddr_d  = base_wrapped;
                    pend1_d  = 1'b1;
                    issued_d = AW'(1);
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                if (issued_q == total_q) begin
                    state_d = S_DRAIN;
                end else if (can_issue) begin
                    raddr_d  = next_addr;
                    pend1_d  = 1'b1;
                    issued_d = issued_q + 1'b1;
                end
            end
            S_DRAIN: if (pop && out_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            raddr_q  <= '0;
            issued_q <= '0;
            total_q  <= '0;
            beats_q  <= '0;
            pend1_q  <= 1'b0;
            pend2_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            state_q  <= state_d;
            raddr_q  <= raddr_d;
            issued_q <= issued_d;
            total_q  <= total_d;
            beats_q  <= beats_d;
            pend1_q  <= pend1_d;
            pend2_q  <= pend1_q;
            occ_q    <= occ_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: FIFO storage has no reset; occupancy gates out_data, so stale entries are never seen.
    always_ff @(posedge Clk) begin
        if (push) fifo_q[wr_ptr_q] <= rdata;
    end

`ifdef NEO_PEAK_EN
    logic signed [N-1:0] run_max_q, run_max_d, peak_val_q, peak_val_d;
    logic [AW-1:0]       run_idx_q, run_idx_d, peak_idx_q, peak_idx_d;
    logic                run_any_q, run_any_d;

    always_comb begin
        run_max_d  = run_max_q;
        run_idx_d  = run_idx_q;
        run_any_d  = run_any_q;
        peak_val_d = peak_val_q;
        peak_idx_d = peak_idx_q;
        if (state_q == S_IDLE && start) begin
            run_max_d = '0;
            run_idx_d = '0;
            run_any_d = 1'b0;
        end
        // Strict compare: ties keep the earliest offset.
        if (pop && (!run_any_q || out_data > run_max_q)) begin
            run_max_d = out_data;
            run_idx_d = beats_q;
        end
        if (pop) run_any_d = 1'b1;
        if (state_d == S_DONE && state_q != S_DONE) begin
            peak_val_d = run_max_d;
            peak_idx_d = run_idx_d;
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            run_max_q  <= '0;
            run_idx_q  <= '0;
            run_any_q  <= 1'b0;
            peak_val_q <= '0;
            peak_idx_q <= '0;
        end else begin
            run_max_q  <= run_max_d;
            run_idx_q  <= run_idx_d;
            run_any_q  <= run_any_d;
            peak_val_q <= peak_val_d;
            peak_idx_q <= peak_idx_d;
        end
    end

    assign peak_val = peak_val_q;
    assign peak_idx = peak_idx_q;
`endif

endmodule

// File: tb/tb_neo_result_reader.sv
// Directed bench for neo_result_reader with a synchronous-read memory model.
module tb_neo_result_reader;

    localparam int N  = 16;
    localparam int M  = 16;
    localparam int AW = 5;

    logic                Clk;
    logic                reset;
    logic                start;
    logic [AW-1:0]       base_addr, count, raddr;
    logic signed [N-1:0] rdata, out_data;
    logic                out_valid, out_ready, out_last, busy, done;
`ifdef NEO_PEAK_EN
    logic signed [N-1:0] peak_val;
    logic [AW-1:0]       peak_idx;
`endif

    int checks   = 0;
    int failures = 0;

    logic signed [N-1:0] mem [M];
    logic signed [N-1:0] got_q [$];

    neo_result_reader #(.N(N), .M(M)) dut (
        .Clk(Clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
        .raddr(raddr), .rdata(rdata), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
`ifdef NEO_PEAK_EN
       ,.peak_val(peak_val), .peak_idx(peak_idx)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) rdata <= mem[raddr[3:0]];

    // Runs one transfer; mode 1 applies the 1,0,0,1 ready pattern plus a stray start.
    task automatic run_xfer(input logic [AW-1:0] b, input logic [AW-1:0] c, input int mode,
                            output int last_pos, output int done_seen, output int held_err);
        logic                prev_stall;
        logic signed [N-1:0] prev_data;
        got_q.delete();
        last_pos = -1; done_seen = 0; held_err = 0; prev_stall = 1'b0; prev_data = '0;
        base_addr = b; count = c; start = 1'b1; out_ready = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (done) begin done_seen = 1; break; end
            if (mode == 1) begin
                out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                start     = (cyc == 3);
                base_addr = 5'd0; count = 5'd2;
            end
            if (prev_stall && (!out_valid || out_data !== prev_data)) held_err++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                if (out_last) last_pos = got_q.size() - 1;
            end
            @(posedge Clk); #1;
        end
        start = 1'b0; out_ready = 1'b1;
        @(posedge Clk); #1;
    endtask

    task automatic check_xfer(input string name, input logic [AW-1:0] b, input int n,
                              input int last_pos, input int done_seen, input int held_err);
        checks++;
        if (done_seen !== 1) begin failures++; $display("FAIL %s done: got %0d want 1", name, done_seen); end
        checks++;
        if (got_q.size() !== n) begin failures++; $display("FAIL %s beats: got %0d want %0d", name, got_q.size(), n); end
        checks++;
        if (n > 0 && last_pos !== n - 1) begin failures++; $display("FAIL %s last_pos: got %0d want %0d", name, last_pos, n - 1); end
        checks++;
        if (held_err !== 0) begin failures++; $display("FAIL %s held: got %0d want 0", name, held_err); end
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== mem[(b + i) % M]) begin
                failures++;
                $display("FAIL %s word%0d: got %0d want %0d", name, i, got_q[i], mem[(b + i) % M]);
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({raddr, out_data, out_valid, out_last, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got raddr=%0d data=%0d v=%b l=%b busy=%b done=%b want all 0",
                     raddr, out_data, out_valid, out_last, busy, done);
        end
    endtask

    task automatic test_basic();
        logic signed [N-1:0] exp_d [4];
        exp_d = '{16'sd0, 16'sd3, 16'sd6, 16'sd9};
        for (int i = 0; i < M; i++) mem[i] = 16'(i * 3);
        out_ready = 1'b1; base_addr = 5'd0; count = 5'd4; start = 1'b1;
        @(posedge Clk); #1; start = 1'b0;
        checks++;
        if (busy !== 1'b1 || raddr !== 5'd0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL basic_e0: got busy=%b raddr=%0d v=%b want 1,0,0", busy, raddr, out_valid);
        end
        @(posedge Clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_e1_valid: got %b want 0", out_valid); end
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_last !== (i == 3)) begin
                failures++;
                $display("FAIL basic_beat%0d: got v=%b d=%0d l=%b want 1,%0d,%b", i, out_valid, out_data, out_last, exp_d[i], i == 3);
            end
        end
        @(posedge Clk); #1;
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL basic_done: got done=%b v=%b want 1,0", done, out_valid); end
        @(posedge Clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_idle: got done=%b busy=%b want 0,0", done, busy); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_a [4];
        exp_a = '{5'd14, 5'd15, 5'd0, 5'd1};
        for (int i = 0; i < M; i++) mem[i] = 16'(100 + i);
        out_ready = 1'b1; base_addr = 5'd14; count = 5'd4; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk); #1; start = 1'b0;
            checks++;
            if (raddr !== exp_a[i]) begin failures++; $display("FAIL wrap_raddr%0d: got %0d want %0d", i, raddr, exp_a[i]); end
        end
        repeat (6) @(posedge Clk);
        #1;
        begin
            int lp, ds, he;
            run_xfer(5'd14, 5'd4, 0, lp, ds, he);
            check_xfer("wrap", 5'd14, 4, lp, ds, he);
        end
    endtask

    task automatic test_back_to_back();
        int lp, ds, he;
        for (int i = 0; i < M; i++) mem[i] = 16'(5 - i * 7);
        run_xfer(5'd3, 5'd8, 1, lp, ds, he);
        check_xfer("backpressure", 5'd3, 8, lp, ds, he);
    endtask

    task automatic test_boundaries();
        int lp, ds, he;
        run_xfer(5'd6, 5'd0, 0, lp, ds, he);
        check_xfer("count0", 5'd6, 0, lp, ds, he);
        run_xfer(5'd9, 5'd1, 0, lp, ds, he);
        check_xfer("count1", 5'd9, 1, lp, ds, he);
        run_xfer(5'd0, 5'd20, 0, lp, ds, he);
        check_xfer("count20", 5'd0, 16, lp, ds, he);
    endtask

    task automatic test_reset_mid();
        int lp, ds, he;
        out_ready = 1'b0; base_addr = 5'd0; count = 5'd8; start = 1'b1;
        @(posedge Clk); #1; start = 1'b0;
        repeat (3) @(posedge Clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({raddr, out_data, out_valid, out_last, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_mid: got raddr=%0d data=%0d v=%b l=%b busy=%b done=%b want all 0",
                     raddr, out_data, out_valid, out_last, busy, done);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_hold%0d: got done=%b busy=%b want 0,0", i, done, busy); end
        end
        reset = 1'b1; out_ready = 1'b1;
        @(posedge Clk); #1;
        run_xfer(5'd5, 5'd2, 0, lp, ds, he);
        check_xfer("restart", 5'd5, 2, lp, ds, he);
    endtask

`ifdef NEO_PEAK_EN
    task automatic test_peak();
        int lp, ds, he;
        mem[0] = 16'sd5; mem[1] = -16'sd2; mem[2] = 16'sd9; mem[3] = 16'sd9; mem[4] = 16'sd1;
        base_addr = 5'd0; count = 5'd5; start = 1'b1; out_ready = 1'b1;
        @(posedge Clk); #1; start = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin @(posedge Clk); #1; end
        checks++;
        if (done !== 1'b1 || peak_val !== 16'sd9 || peak_idx !== 5'd2) begin
            failures++; $display("FAIL peak: got done=%b val=%0d idx=%0d want 1,9,2", done, peak_val, peak_idx);
        end
        @(posedge Clk); #1;
        run_xfer(5'd0, 5'd0, 0, lp, ds, he);
        checks++;
        if (peak_val !== '0 || peak_idx !== '0) begin
            failures++; $display("FAIL peak_count0: got val=%0d idx=%0d want 0,0", peak_val, peak_idx);
        end
    endtask
`endif

    initial begin
        reset = 1'b0; start = 1'b0; out_ready = 1'b0; base_addr = '0; count = '0;
        for (int i = 0; i < M; i++) mem[i] = '0;
        repeat (3) @(posedge Clk);
        #1;
        test_reset();
        reset = 1'b1;
        @(posedge Clk); #1;
        test_basic();
        test_wrap();
        test_back_to_back();
        test_boundaries();
        test_reset_mid();
`ifdef NEO_PEAK_EN
        test_peak();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
